fifo_burst_driver: RTL and testbench

Synthesizable write-side traffic generator for the async FIFO, clocked in the write domain.
- Replaces ad-hoc write loops with a parametrised burst engine. Burst count, burst length, inter-burst gap and data pattern are programmable.
- Honours FIFO backpressure (full) and reports progress.
- Sits between the bench/top-level control and the FIFO write port (wr_en, data_in, full, half).

---
 rtl/fifo_burst_driver.sv | 218 +++++++++++++++++++++
 tb/tb_fifo_burst_driver.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_driver.sv
// fifo_burst_driver
//   Write-side traffic generator for the async FIFO, clocked in the write
//   domain. Issues num_bursts bursts of burst_len words, separated by
//   idle_cycles idle cycles, with a selectable data pattern. Honours the
//   FIFO full flag and reports progress.
//
//   Build option: define FIFO_DRV_HALF_THROTTLE_EN to also pause writes
//   while the FIFO half flag is set. Without it half_i is ignored.
//
// Ports
//   clk_wr           write-domain clock
//   rst_n            asynchronous active-low reset
//   start_i          start request, sampled only in IDLE
//   burst_len_i      words per burst (clamped to BURST_MAX)
//   idle_cycles_i    idle cycles between bursts
//   num_bursts_i     number of bursts
//   mode_i           pattern: 00 incr, 01 LFSR, 10 walking one, 11 alternating
//   full_i           FIFO full flag (registered in write domain)
//   half_i           FIFO half flag
//   wr_en_o          FIFO write enable
//   data_in_o        FIFO write data
//   busy_o           sequence in progress (BURST or GAP)
//   done_o           one-cycle completion pulse
//   words_written_o  accepted writes since last start, saturating
//
// state | meaning
// IDLE  | waiting for start_i; latches configuration on start
// BURST | writing words; wr_en_o high unless backpressured
// GAP   | idle_cycles cycles with no writes between bursts
// DONE  | single cycle, done_o pulses, then back to IDLE

module fifo_burst_driver #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_MAX  = 64,
  parameter int unsigned IDLE_WIDTH = 4,
  parameter int unsigned LFSR_SEED  = 32'h01
) (
  input  logic                             clk_wr,
  input  logic                             rst_n,
  input  logic                             start_i,
  input  logic [$clog2(BURST_MAX+1)-1:0]   burst_len_i,
  input  logic [IDLE_WIDTH-1:0]            idle_cycles_i,
  input  logic [7:0]                       num_bursts_i,
  input  logic [1:0]                       mode_i,
  input  logic                             full_i,
  input  logic                             half_i,
  output logic                             wr_en_o,
  output logic [DATA_WIDTH-1:0]            data_in_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [15:0]                      words_written_o
);

  localparam int unsigned LW = $clog2(BURST_MAX + 1);
  localparam logic [DATA_WIDTH-1:0] SEED_RAW = DATA_WIDTH'(LFSR_SEED);
  // An all-zero LFSR would lock up, so a zero seed is forced to 1.
  localparam logic [DATA_WIDTH-1:0] SEED_C =
    (SEED_RAW == '0) ? DATA_WIDTH'(1) : SEED_RAW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [DATA_WIDTH-1:0] alt_pattern();
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      r[i] = (i % 2) == 1;
    end
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pat_start(input logic [1:0] m);
    logic [DATA_WIDTH-1:0] r;
    case (m)
      2'b00:   r = '0;
      2'b01:   r = SEED_C;
      2'b10:   r = DATA_WIDTH'(1);
      default: r = alt_pattern();
    endcase
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pat_next(input logic [1:0] m,
                                                     input logic [DATA_WIDTH-1:0] c);
    logic [DATA_WIDTH-1:0] r;
    case (m)
      2'b00:   r = c + DATA_WIDTH'(1);
      2'b01:   r = {c[DATA_WIDTH-2:0],
                    c[DATA_WIDTH-1] ^ c[DATA_WIDTH-3] ^ c[DATA_WIDTH-4] ^ c[DATA_WIDTH-5]};
      2'b10:   r = {c[DATA_WIDTH-2:0], c[DATA_WIDTH-1]};
      default: r = ~c;
    endcase
    return r;
  endfunction

  state_t                 state_q, state_d;
  logic [LW-1:0]          len_q, len_d;
  logic [IDLE_WIDTH-1:0]  idle_q, idle_d;
  logic [7:0]             nb_q, nb_d;
  logic [1:0]             mode_q, mode_d;
  logic [DATA_WIDTH-1:0]  pat_q, pat_d;
  logic [LW-1:0]          beat_q, beat_d;
  logic [7:0]             burst_q, burst_d;
  logic [IDLE_WIDTH-1:0]  gap_q, gap_d;
  logic [15:0]            words_q, words_d;

  logic [LW-1:0]          len_clamped;
  logic                   wr_en_c;

  assign len_clamped = (burst_len_i > LW'(BURST_MAX)) ? LW'(BURST_MAX) : burst_len_i;

`ifdef FIFO_DRV_HALF_THROTTLE_EN
  assign wr_en_c = (state_q == BURST) && !full_i && !half_i;
`else
  logic unused_half;
  assign unused_half = half_i;
  assign wr_en_c = (state_q == BURST) && !full_i;
`endif

  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      idle_q  <= '0;
      nb_q    <= '0;
      mode_q  <= '0;
      pat_q   <= '0;
      beat_q  <= '0;
      burst_q <= '0;
      gap_q   <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idle_q  <= idle_d;
      nb_q    <= nb_d;
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      beat_q  <= beat_d;
      burst_q <= burst_d;
      gap_q   <= gap_d;
      words_q <= words_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idle_d  = idle_q;
    nb_d    = nb_q;
    mode_d  = mode_q;
    pat_d   = pat_q;
    beat_d  = beat_q;
    burst_d = burst_q;
    gap_d   = gap_q;
    words_d = words_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d   = len_clamped;
          idle_d  = idle_cycles_i;
          nb_d    = num_bursts_i;
          mode_d  = mode_i;
          pat_d   = pat_start(mode_i);
          beat_d  = '0;
          burst_d = '0;
          words_d = '0;
          if (len_clamped == '0 || num_bursts_i == 8'd0) state_d = DONE;
          else                                           state_d = BURST;
        end
      end

      BURST: begin
        if (wr_en_c) begin
          pat_d = pat_next(mode_q, pat_q);
          if (words_q != 16'hFFFF) words_d = words_q + 16'd1;
          if (beat_q + LW'(1) == len_q) begin
            beat_d  = '0;
            burst_d = burst_q + 8'd1;
            if (burst_q + 8'd1 == nb_q) begin
              state_d = DONE;
            end else if (idle_q != '0) begin
              state_d = GAP;
              gap_d   = idle_q;
            end
          end else begin
            beat_d = beat_q + LW'(1);
          end
        end
      end

      GAP: begin
        // gap_q counts down from idle_q; the cycle showing 1 is the last one.
        if (gap_q <= IDLE_WIDTH'(1)) begin
          gap_d   = '0;
          state_d = BURST;
        end else begin
          gap_d = gap_q - IDLE_WIDTH'(1);
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign wr_en_o         = wr_en_c;
  assign data_in_o       = pat_q;
  assign busy_o          = (state_q == BURST) || (state_q == GAP);
  assign done_o          = (state_q == DONE);
  assign words_written_o = words_q;

endmodule

// File: tb/tb_fifo_burst_driver.sv
// Directed bench for fifo_burst_driver (default parameters, 8-bit data).
// Inputs are driven on the falling edge; outputs are checked 1 time unit later.

module tb_fifo_burst_driver;

  logic        clk_wr;
  logic        rst_n;
  logic        start_i;
  logic [6:0]  burst_len_i;
  logic [3:0]  idle_cycles_i;
  logic [7:0]  num_bursts_i;
  logic [1:0]  mode_i;
  logic        full_i;
  logic        half_i;
  logic        wr_en_o;
  logic [7:0]  data_in_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] words_written_o;

  int errors = 0;
  int checks = 0;

  fifo_burst_driver dut (
    .clk_wr          (clk_wr),
    .rst_n           (rst_n),
    .start_i         (start_i),
    .burst_len_i     (burst_len_i),
    .idle_cycles_i   (idle_cycles_i),
    .num_bursts_i    (num_bursts_i),
    .mode_i          (mode_i),
    .full_i          (full_i),
    .half_i          (half_i),
    .wr_en_o         (wr_en_o),
    .data_in_o       (data_in_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .words_written_o (words_written_o)
  );

  initial clk_wr = 1'b0;
  always #5 clk_wr = ~clk_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_seq(input logic [6:0] len, input logic [7:0] nb,
                           input logic [3:0] idle, input logic [1:0] mode);
    @(negedge clk_wr);
    burst_len_i   = len;
    num_bursts_i  = nb;
    idle_cycles_i = idle;
    mode_i        = mode;
    full_i        = 1'b0;
    half_i        = 1'b0;
    start_i       = 1'b1;
  endtask

  task automatic step(input logic f, input logic h);
    @(negedge clk_wr);
    start_i = 1'b0;
    full_i  = f;
    half_i  = h;
    #1;
  endtask

  task automatic chk_beat(input string tag, input int i, input logic ew, input logic [7:0] ed);
    chk($sformatf("%s_wr[%0d]", tag, i), wr_en_o, ew);
    chk($sformatf("%s_data[%0d]", tag, i), data_in_o, ed);
  endtask

  task automatic chk_done(input string tag, input logic [15:0] words);
    chk({tag, "_done"}, done_o, 1'b1);
    chk({tag, "_busy_in_done"}, busy_o, 1'b0);
    chk({tag, "_wr_in_done"}, wr_en_o, 1'b0);
    chk({tag, "_words"}, words_written_o, words);
  endtask

  initial begin
    logic [7:0] ed[16];
    logic       ew[16];
    int         nw;
    bit         seen;

    rst_n = 1'b0; start_i = 1'b0; burst_len_i = '0; idle_cycles_i = '0;
    num_bursts_i = '0; mode_i = '0; full_i = 1'b0; half_i = 1'b0;

    // reset state
    @(negedge clk_wr); #1;
    chk("rst_wr", wr_en_o, 1'b0);
    chk("rst_data", data_in_o, 8'h00);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_words", words_written_o, 16'h0);
    @(negedge clk_wr);
    rst_n = 1'b1;

    // 1: incrementing, 4 words, one burst
    start_seq(7'd4, 8'd1, 4'd0, 2'b00);
    ed[0:3] = '{8'h00, 8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 4; i++) begin
      step(0, 0);
      chk_beat("t1", i, 1'b1, ed[i]);
      chk($sformatf("t1_busy[%0d]", i), busy_o, 1'b1);
    end
    step(0, 0); chk_done("t1", 16'd4);
    step(0, 0);
    chk("t1_done_low", done_o, 1'b0);
    chk("t1_idle_busy", busy_o, 1'b0);

    // 2: walking one, 2 bursts of 3, gap 2
    start_seq(7'd3, 8'd2, 4'd2, 2'b10);
    ew = '{1,1,1,0,0,1,1,1,0,0,0,0,0,0,0,0};
    ed = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h08, 8'h08, 8'h10, 8'h20,
           8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) begin
      step(0, 0);
      chk_beat("t2", i, ew[i], ed[i]);
      chk($sformatf("t2_busy[%0d]", i), busy_o, 1'b1);
    end
    step(0, 0); chk_done("t2", 16'd6);

    // 3: LFSR from seed 01
    start_seq(7'd5, 8'd1, 4'd0, 2'b01);
    ed[0:4] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    for (int i = 0; i < 5; i++) begin
      step(0, 0);
      chk_beat("t3", i, 1'b1, ed[i]);
    end
    step(0, 0); chk_done("t3", 16'd5);

    // 4: full for 3 cycles after the 2nd write
    start_seq(7'd8, 8'd1, 4'd0, 2'b00);
    ew = '{1,1,0,0,0,1,1,1,1,1,1,0,0,0,0,0};
    ed = '{8'h00, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h03, 8'h04,
           8'h05, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 11; i++) begin
      step((i >= 2 && i <= 4), 0);
      chk_beat("t4", i, ew[i], ed[i]);
    end
    step(0, 0); chk_done("t4", 16'd8);

    // 5: async reset after 5 of 16 writes, then restart
    start_seq(7'd16, 8'd1, 4'd0, 2'b00);
    for (int i = 0; i < 6; i++) begin
      step(0, 0);
      chk_beat("t5", i, 1'b1, 8'(i));
    end
    chk("t5_words_pre", words_written_o, 16'd5);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_wr", wr_en_o, 1'b0);
    chk("t5_rst_busy", busy_o, 1'b0);
    chk("t5_rst_words", words_written_o, 16'd0);
    chk("t5_rst_data", data_in_o, 8'h00);
    @(negedge clk_wr);
    rst_n = 1'b1;
    start_seq(7'd2, 8'd1, 4'd0, 2'b00);
    step(0, 0); chk_beat("t5r", 0, 1'b1, 8'h00);
    step(0, 0); chk_beat("t5r", 1, 1'b1, 8'h01);
    step(0, 0); chk_done("t5r", 16'd2);

    // 6: zero length, and zero bursts: straight to DONE
    start_seq(7'd0, 8'd3, 4'd0, 2'b00);
    step(0, 0); chk_done("t6len", 16'd0);
    step(0, 0);
    chk("t6len_done_low", done_o, 1'b0);
    chk("t6len_busy", busy_o, 1'b0);
    start_seq(7'd5, 8'd0, 4'd0, 2'b00);
    step(0, 0); chk_done("t6nb", 16'd0);

    // alternating pattern, back-to-back bursts (idle 0)
    start_seq(7'd2, 8'd2, 4'd0, 2'b11);
    ed[0:3] = '{8'hAA, 8'h55, 8'hAA, 8'h55};
    for (int i = 0; i < 4; i++) begin
      step(0, 0);
      chk_beat("alt", i, 1'b1, ed[i]);
    end
    step(0, 0); chk_done("alt", 16'd4);

    // full rising on the last beat blocks it and delays DONE
    start_seq(7'd2, 8'd1, 4'd0, 2'b00);
    step(0, 0); chk_beat("lastfull", 0, 1'b1, 8'h00);
    step(1, 0); chk_beat("lastfull", 1, 1'b0, 8'h01);
    chk("lastfull_busy", busy_o, 1'b1);
    step(0, 0); chk_beat("lastfull", 2, 1'b1, 8'h01);
    step(0, 0); chk_done("lastfull", 16'd2);

    // burst_len above BURST_MAX is clamped to 64
    start_seq(7'd100, 8'd1, 4'd0, 2'b00);
    nw = 0;
    seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      step(0, 0);
      if (done_o) begin
        seen = 1;
        chk("clamp_words", words_written_o, 16'd64);
      end else if (wr_en_o) begin
        chk($sformatf("clamp_data[%0d]", nw), data_in_o, nw[7:0]);
        nw++;
      end
    end
    chk("clamp_count", nw, 64);
    chk("clamp_done_seen", seen, 1'b1);

    // 7: half asserted for 2 cycles mid-burst
    start_seq(7'd6, 8'd1, 4'd0, 2'b00);
`ifdef FIFO_DRV_HALF_THROTTLE_EN
    ew = '{1,1,0,0,1,1,1,1,0,0,0,0,0,0,0,0};
    ed = '{8'h00, 8'h01, 8'h02, 8'h02, 8'h02, 8'h03, 8'h04, 8'h05,
           8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) begin
      step(0, (i == 2 || i == 3));
      chk_beat("t7", i, ew[i], ed[i]);
    end
`else
    for (int i = 0; i < 6; i++) begin
      step(0, (i == 2 || i == 3));
      chk_beat("t7", i, 1'b1, 8'(i));
    end
`endif
    step(0, 0); chk_done("t7", 16'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
